// File: rtl/operand_rr_arbiter.sv
// Six-way round-robin arbiter feeding a registered 16-bit operand channel.
// Optional per-owner burst mode is enabled by defining ARB_BURST_EN.
module operand_rr_arbiter #(
  parameter int W     = 16,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [5:0]     req,
  input  logic [6*W-1:0] din,
  output logic [5:0]     gnt,
  output logic [2:0]     sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  input  logic           out_ready
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     fsm;
  logic [2:0] owner;
  logic [2:0] ptr;
`ifdef ARB_BURST_EN
  logic [3:0] cnt;
`endif

  logic         can_load;
  logic         rel;
  logic [2:0]   rel_start;
  logic [3:0]   pick_idle;
  logic [3:0]   pick_rel;
  logic         win_vld;
  logic [2:0]   win_idx;
  logic         go_idle;
  logic         fire;
  logic [W-1:0] win_data;

  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("operand_rr_arbiter: BURST must be in 1..15");
  end

  // {found, index}: first requester at or after start, modulo 6
  function automatic logic [3:0] pick(input logic [5:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [3:0] s;
    res = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      s = {1'b0, start} + 4'(k);
      if (s >= 4'd6) s = s - 4'd6;
      if (!res[3] && r[s[2:0]]) res = {1'b1, s[2:0]};
    end
    return res;
  endfunction

  assign can_load  = !out_valid || out_ready;
  assign rel_start = (owner == 3'd5) ? 3'd0 : owner + 3'd1;
  assign pick_idle = pick(req, ptr);
  assign pick_rel  = pick(req, rel_start);

`ifdef ARB_BURST_EN
  assign rel = !req[owner] || (cnt == 4'(BURST));
`else
  assign rel = 1'b1;
`endif

  always_comb begin
    win_vld = 1'b0;
    win_idx = owner;
    go_idle = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (can_load && pick_idle[3]) begin
          win_vld = 1'b1;
          win_idx = pick_idle[2:0];
        end
      end
      OWN: begin
        if (!rel) begin
          win_vld = can_load;
        end else if (!pick_rel[3]) begin
          go_idle = 1'b1;
        end else if (can_load) begin
          win_vld = 1'b1;
          win_idx = pick_rel[2:0];
        end
      end
      default: ;
    endcase
  end

  // Data mux keyed on the winner index so din never reaches gnt/sel
  always_comb begin
    win_data = din[W-1:0];
    for (int unsigned i = 0; i < 6; i++) begin
      if (win_idx == 3'(i)) win_data = din[i*W +: W];
    end
  end

  assign fire = win_vld && rst_n;
  assign gnt  = fire ? (6'(1) << win_idx) : '0;
  assign sel  = fire ? win_idx : owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      owner     <= '0;
      ptr       <= '0;
`ifdef ARB_BURST_EN
      cnt       <= '0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      if (win_vld) begin
        fsm       <= OWN;
        owner     <= win_idx;
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= win_idx;
        if (fsm == OWN && rel) ptr <= rel_start;
`ifdef ARB_BURST_EN
        cnt <= (fsm == OWN && !rel) ? cnt + 4'd1 : 4'd1;
`endif
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (go_idle) begin
          fsm <= IDLE;
          ptr <= rel_start;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_rr_arbiter.sv
// Self-checking bench for operand_rr_arbiter: directed scenarios plus random
// traffic checked against a beat-level behavioural model.
module tb_operand_rr_arbiter;
  localparam int W     = 16;
  localparam int BURST = 4;
`ifdef ARB_BURST_EN
  localparam int BEFF = BURST;
`else
  localparam int BEFF = 1;
`endif

  logic           clk;
  logic           rst_n;
  logic [5:0]     req;
  logic [6*W-1:0] din;
  logic [5:0]     gnt;
  logic [2:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  operand_rr_arbiter #(.W(W), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // reference model: ownership + single-entry output buffer
  bit           m_busy;
  int           m_owner, m_beats, m_ptr;
  bit           mv;
  logic [W-1:0] md;
  int           ms;

  function automatic int first_from(input logic [5:0] r, input int start);
    for (int k = 0; k < 6; k++) if (r[(start + k) % 6]) return (start + k) % 6;
    return -1;
  endfunction

  function automatic logic [5:0] onehot(input int w);
    logic [5:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    mv = 0; md = '0; ms = 0;
  endtask

  task automatic predict(output int w, output bit cont, output bit to_idle);
    bit can;
    int f;
    can = !mv || out_ready;
    w = -1; cont = 0; to_idle = 0;
    if (!m_busy) begin
      if (can) w = first_from(req, m_ptr);
    end else if (req[m_owner] && m_beats < BEFF) begin
      if (can) begin w = m_owner; cont = 1; end
    end else begin
      f = first_from(req, (m_owner + 1) % 6);
      if (f < 0) to_idle = 1;
      else if (can) w = f;
    end
  endtask

  task automatic commit(input int w, input bit cont, input bit to_idle);
    if (w >= 0) begin
      mv = 1; md = din[w*W +: W]; ms = w;
      if (cont) m_beats++;
      else begin m_owner = w; m_beats = 1; m_busy = 1; end
    end else if (out_ready) mv = 0;
    if (to_idle) begin m_busy = 0; m_ptr = (m_owner + 1) % 6; end
  endtask

  task automatic do_reset();
    req = '0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; din = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req = 6'b111111;
    #1;
    n_tests++; if (gnt !== 6'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=000000", gnt); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_tests++; if (out_sel !== 3'd0 || sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", out_sel, sel); end
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    int w; bit c, ti; int e;
    do_reset();
    for (int i = 0; i < 6; i++) din[i*W +: W] = W'($urandom);
    req = 6'b111111; out_ready = 1'b1;
    for (int k = 0; k < 12 * BEFF + 1; k++) begin
      e = (k / BEFF) % 6;
      predict(w, c, ti);
      #3;
      n_tests++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL rr_gnt beat=%0d got=%b exp=%b", k, gnt, onehot(e)); end
      n_tests++; if (sel !== 3'(e)) begin n_fail++; $display("FAIL rr_sel beat=%0d got=%0d exp=%0d", k, sel, e); end
      @(posedge clk); #1;
      commit(w, c, ti);
      n_tests++; if (out_valid !== 1'b1 || out_sel !== 3'(e)) begin n_fail++; $display("FAIL rr_out beat=%0d got=%b/%0d exp=1/%0d", k, out_valid, out_sel, e); end
      n_tests++; if (out_data !== md) begin n_fail++; $display("FAIL rr_data beat=%0d got=%h exp=%h", k, out_data, md); end
      din[e*W +: W] = W'($urandom);
    end
  endtask

  task automatic test_backpressure();
    int w; bit c, ti;
    logic [W-1:0] a, b;
    do_reset();
    a = 16'hA5C3; b = 16'h1E0F;
    out_ready = 1'b1; req = 6'b000010; din[1*W +: W] = a;
    predict(w, c, ti); #3;
    n_tests++; if (gnt !== 6'b000010) begin n_fail++; $display("FAIL bp_first_gnt got=%b exp=000010", gnt); end
    @(posedge clk); #1; commit(w, c, ti);
    din[1*W +: W] = b; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      predict(w, c, ti); #3;
      n_tests++; if (gnt !== 6'b0) begin n_fail++; $display("FAIL bp_stall_gnt cyc=%0d got=%b exp=000000", k, gnt); end
      @(posedge clk); #1; commit(w, c, ti);
      n_tests++; if (out_valid !== 1'b1 || out_data !== a) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, a); end
    end
    out_ready = 1'b1;
    predict(w, c, ti); #3;
    n_tests++; if (gnt !== 6'b000010 || sel !== 3'd1) begin n_fail++; $display("FAIL bp_resume_gnt got=%b/%0d exp=000010/1", gnt, sel); end
    @(posedge clk); #1; commit(w, c, ti);
    n_tests++; if (out_data !== b || out_sel !== 3'd1) begin n_fail++; $display("FAIL bp_resume_data got=%h/%0d exp=%h/1", out_data, out_sel, b); end
    req = '0;
  endtask

  task automatic test_release();
    int w; bit c, ti;
    do_reset();
    out_ready = 1'b1; req = 6'b001000;
    for (int k = 0; k < 2; k++) begin
      din[3*W +: W] = W'($urandom);
      predict(w, c, ti); #3;
      n_tests++; if (gnt !== 6'b001000) begin n_fail++; $display("FAIL rel_own beat=%0d got=%b exp=001000", k, gnt); end
      @(posedge clk); #1; commit(w, c, ti);
    end
    req = 6'b100001; din[5*W +: W] = 16'h5555;
    predict(w, c, ti); #3;
    n_tests++; if (gnt !== 6'b100000 || sel !== 3'd5) begin n_fail++; $display("FAIL rel_move got=%b/%0d exp=100000/5", gnt, sel); end
    @(posedge clk); #1; commit(w, c, ti);
    n_tests++; if (out_sel !== 3'd5 || out_data !== 16'h5555) begin n_fail++; $display("FAIL rel_out got=%0d/%h exp=5/5555", out_sel, out_data); end
  endtask

  task automatic test_single();
    int w; bit c, ti;
    do_reset();
    out_ready = 1'b1; req = 6'b010000;
    for (int k = 0; k < 3 * BEFF; k++) begin
      din[4*W +: W] = W'($urandom);
      predict(w, c, ti); #3;
      n_tests++; if (gnt !== 6'b010000) begin n_fail++; $display("FAIL single_gnt beat=%0d got=%b exp=010000", k, gnt); end
      @(posedge clk); #1; commit(w, c, ti);
      n_tests++; if (out_data !== md || out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out beat=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, md); end
    end
  endtask

  task automatic test_random();
    int w; bit c, ti;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      predict(w, c, ti); #3;
      n_tests++; if (gnt !== onehot(w)) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", k, gnt, onehot(w)); end
      n_tests++; if (sel !== 3'((w >= 0) ? w : m_owner)) begin n_fail++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", k, sel, (w >= 0) ? w : m_owner); end
      @(posedge clk); #1; commit(w, c, ti);
      n_tests++; if (out_valid !== mv || (mv && (out_data !== md || out_sel !== 3'(ms)))) begin
        n_fail++; $display("FAIL rand_out cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", k, out_valid, out_data, out_sel, mv, md, ms);
      end
      for (int i = 0; i < 6; i++) begin
        if (i == w) begin
          req[i] = $urandom_range(0, 1);
          din[i*W +: W] = W'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          din[i*W +: W] = W'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    req = 6'b111111; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || gnt !== 6'b0) begin n_fail++; $display("FAIL midrst_clear got=%b/%b exp=0/000000", out_valid, gnt); end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset(); out_ready = 1'b1;
    #3;
    n_tests++; if (gnt !== 6'b000001) begin n_fail++; $display("FAIL midrst_first got=%b exp=000001", gnt); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_sel !== 3'd0) begin n_fail++; $display("FAIL midrst_out got=%b/%0d exp=1/0", out_valid, out_sel); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_release();
    test_single();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
